mul_ctrl: RTL and testbench
===========================

MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width, legal values 8/16/32/64.
REQ-002 SHALL have parameter LATENCY, default 1, cycles from mul_a/mul_b to mul_lower/mul_upper of the attached multiplier, legal range 0..8.
REQ-003 SHALL have parameter TAG_WIDTH, default 4, request tag width.
REQ-004 SHALL have parameter DEPTH, default 4, result buffer entries; must be >= LATENCY+1.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-009 SHALL have port req_a / req_b  input  WIDTH each  operands.
REQ-010 SHALL have port req_unsign  input  1  1 = unsigned multiply, 0 = signed.
REQ-011 SHALL have port req_high  input  1  1 = return upper half, 0 = lower half.
REQ-012 SHALL have port req_tag  input  TAG_WIDTH  opaque ID returned with the result.
REQ-013 SHALL have port mul_a / mul_b  output  WIDTH each  multiplier operands.
REQ-014 SHALL have port mul_unsign  output  1  multiplier signedness.
REQ-015 SHALL have port mul_lower / mul_upper  input  WIDTH each  multiplier product halves.
REQ-016 SHALL have port rsp_valid  output  1  result present.
REQ-017 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-018 SHALL have port rsp_data / rsp_tag  output  WIDTH / TAG_WIDTH  result and its tag.

Function
REQ-019 SHALL drive mul_a, mul_b and mul_unsign combinationally from req_a, req_b and req_unsign.
REQ-020 SHALL define fire = req_valid & req_ready.
REQ-021 SHALL keep a LATENCY-deep shift pipe of {valid, high, tag}; stage 0 loads {fire, req_high, req_tag} each cycle.
REQ-022 SHALL, when pipe output valid is set, write {req_high ? mul_upper : mul_lower, tag} into the result FIFO that same cycle.
REQ-023 SHALL, for LATENCY=0, write the FIFO directly on fire using the same-cycle mul outputs.
REQ-024 SHALL keep credits = DEPTH - (FIFO occupancy + in-flight pipe entries), and drive req_ready = (credits != 0) & ~rst, so the FIFO never overflows.
REQ-025 SHALL update credits as: -1 on fire, +1 on rsp_valid & rsp_ready; both in one cycle leave it unchanged.
REQ-026 SHALL implement the FIFO as DEPTH entries with wrapping read/write pointers and a count; write and read in the same cycle are both legal, including at full and empty.
REQ-027 SHALL drive rsp_valid = (count != 0), with rsp_data/rsp_tag from the head entry, registered (no write-to-read bypass).
REQ-028 SHALL make minimum request-to-rsp_valid latency LATENCY+1 cycles.
REQ-029 SHALL keep rsp_data/rsp_tag stable while rsp_valid & ~rsp_ready.
REQ-030 SHALL return results in request order; sustained throughput 1 op/cycle while rsp_ready=1.
REQ-031 SHALL give operands no meaning when req_valid=0; pipe valid is 0 for that slot.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, clear all pipe valid bits, set FIFO pointers and count to 0, and set credits to DEPTH.
REQ-033 SHALL hold rsp_valid=0 and req_ready=0 during rst, and set req_ready=1 on the first cycle after deassertion.
REQ-034 SHALL drop, and never emit, operations in flight when rst asserts mid-operation.
REQ-035 SHALL leave FIFO data storage un-reset; rsp_data/rsp_tag are don't-care while rsp_valid=0.

Verification
REQ-036 SHALL cover single op, WIDTH=8, LATENCY=1: a=0xFF, b=0x02, unsign=1, high=0, tag=3 -> rsp_valid at cycle 2, rsp_data=0xFE, rsp_tag=3; same with high=1 -> rsp_data=0x01.
REQ-037 SHALL cover signed: a=0xFF, b=0x02, unsign=0, high=1 -> rsp_data=0xFF; with high=0 -> rsp_data=0xFE.
REQ-038 SHALL cover backpressure, DEPTH=4, rsp_ready=0, 6 back-to-back requests -> exactly 4 accepted and req_ready=0 afterwards; rsp_ready=1 -> tags drained in order 0,1,2,3 with one acceptance per freed credit.
REQ-039 SHALL cover streaming, rsp_ready=1, 16 consecutive requests -> req_ready never drops, 16 responses on consecutive cycles, results match a reference model.
REQ-040 SHALL cover rst asserted for 1 cycle with 2 ops in flight and 1 buffered -> rsp_valid=0 next cycle, no stale response ever emitted, credits back at 4.
REQ-041 SHALL cover LATENCY=0 and LATENCY=3 builds with random traffic and random rsp_ready -> ordering, data and tags correct, no overflow.

Source files
------------

// File: rtl/mul_ctrl.sv
// mul_ctrl: request/response front end for an external fixed-latency multiplier.
// Operands go straight to the multiplier; a small shift pipe tracks which
// cycles carry a real request, and completed results land in a credit-managed
// FIFO so the consumer can apply backpressure without losing anything.
module mul_ctrl #(
   parameter int WIDTH     = 8,
   parameter int LATENCY   = 1,
   parameter int TAG_WIDTH = 4,
   parameter int DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [WIDTH-1:0]     req_a,
   input  logic [WIDTH-1:0]     req_b,
   input  logic                 req_unsign,
   input  logic                 req_high,
   input  logic [TAG_WIDTH-1:0] req_tag,
   output logic [WIDTH-1:0]     mul_a,
   output logic [WIDTH-1:0]     mul_b,
   output logic                 mul_unsign,
   input  logic [WIDTH-1:0]     mul_lower,
   input  logic [WIDTH-1:0]     mul_upper,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WIDTH-1:0]     rsp_data,
   output logic [TAG_WIDTH-1:0] rsp_tag
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [WIDTH-1:0]     data;
      logic [TAG_WIDTH-1:0] tag;
   } entry_t;

   logic                 fire;
   logic                 rd_en;
   logic                 wr_en;
   logic                 wr_high;
   logic [TAG_WIDTH-1:0] wr_tag;
   entry_t               wr_entry;
   logic [CNT_W-1:0]     credits;
   logic [CNT_W-1:0]     count;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   entry_t               mem [DEPTH];

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // The multiplier sees the request operands directly; its result comes back
   // LATENCY cycles later and is matched up with the pipe entry below.
   assign mul_a      = req_a;
   assign mul_b      = req_b;
   assign mul_unsign = req_unsign;

   // Credits cover both buffered results and products still in the multiplier,
   // so accepting only while credits remain guarantees a free FIFO slot later.
   assign req_ready = (credits != '0) & ~rst;
   assign fire      = req_valid & req_ready;
   assign rsp_valid = (count != '0) & ~rst;
   assign rd_en     = rsp_valid & rsp_ready;

   generate
      if (LATENCY == 0) begin : g_direct
         assign wr_en   = fire;
         assign wr_high = req_high;
         assign wr_tag  = req_tag;
      end else begin : g_pipe
         logic                 pipe_valid [LATENCY];
         logic                 pipe_high  [LATENCY];
         logic [TAG_WIDTH-1:0] pipe_tag   [LATENCY];

         // Shift the request descriptor alongside the multiplier's internal pipeline.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < LATENCY; i++) pipe_valid[i] <= 1'b0;
            end else begin
               pipe_valid[0] <= fire;
               for (int i = 1; i < LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
            end
            pipe_high[0] <= req_high;
            pipe_tag[0]  <= req_tag;
            for (int i = 1; i < LATENCY; i++) begin
               pipe_high[i] <= pipe_high[i-1];
               pipe_tag[i]  <= pipe_tag[i-1];
            end
         end

         assign wr_en   = pipe_valid[LATENCY-1];
         assign wr_high = pipe_high[LATENCY-1];
         assign wr_tag  = pipe_tag[LATENCY-1];
      end
   endgenerate

   assign wr_entry.data = wr_high ? mul_upper : mul_lower;
   assign wr_entry.tag  = wr_tag;

   // Result storage is left un-reset; only the pointers and count decide validity.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_entry;
   end

   // FIFO bookkeeping; simultaneous write and read leave the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= ptr_next(wr_ptr);
         if (rd_en) rd_ptr <= ptr_next(rd_ptr);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // A credit is consumed on acceptance and returned when the consumer takes a result.
   always_ff @(posedge clk) begin
      if (rst) begin
         credits <= CNT_W'(DEPTH);
      end else begin
         case ({fire, rd_en})
            2'b10:   credits <= credits - CNT_W'(1);
            2'b01:   credits <= credits + CNT_W'(1);
            default: credits <= credits;
         endcase
      end
   end

   assign rsp_data = mem[rd_ptr].data;
   assign rsp_tag  = mem[rd_ptr].tag;

endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: drives three mul_ctrl builds (LATENCY 1, 0 and 3, DEPTH 4) from a
// shared request/response stream. Each build has its own multiplier model and
// an in-order scoreboard whose expected results come from plain integer math.
module tb_mul_ctrl;

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic       req_unsign;
   logic       req_high;
   logic [3:0] req_tag;
   logic       rsp_ready;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Expected response from the arithmetic definition of a signed/unsigned product.
   function automatic exp_t refResult(input logic [7:0] a, input logic [7:0] b,
                                      input logic uns, input logic high, input logic [3:0] tag);
      int   pa;
      int   pb;
      int   p;
      exp_t e;
      pa = uns ? int'(a) : int'($signed(a));
      pb = uns ? int'(b) : int'($signed(b));
      p  = pa * pb;
      e.data = high ? p[15:8] : p[7:0];
      e.tag  = tag;
      return e;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

      logic       req_ready;
      logic [7:0] mul_a;
      logic [7:0] mul_b;
      logic       mul_unsign;
      logic [7:0] mul_lower;
      logic [7:0] mul_upper;
      logic       rsp_valid;
      logic [7:0] rsp_data;
      logic [3:0] rsp_tag;
      logic [15:0] prod_now;
      exp_t       sb [$];

      mul_ctrl #(.WIDTH(8), .LATENCY(LAT), .TAG_WIDTH(4), .DEPTH(4)) dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (req_valid),
         .req_ready  (req_ready),
         .req_a      (req_a),
         .req_b      (req_b),
         .req_unsign (req_unsign),
         .req_high   (req_high),
         .req_tag    (req_tag),
         .mul_a      (mul_a),
         .mul_b      (mul_b),
         .mul_unsign (mul_unsign),
         .mul_lower  (mul_lower),
         .mul_upper  (mul_upper),
         .rsp_valid  (rsp_valid),
         .rsp_ready  (rsp_ready),
         .rsp_data   (rsp_data),
         .rsp_tag    (rsp_tag)
      );

      // Attached multiplier: 16-bit product of extended operands, delayed LAT cycles.
      assign prod_now = {{8{~mul_unsign & mul_a[7]}}, mul_a} * {{8{~mul_unsign & mul_b[7]}}, mul_b};

      if (LAT == 0) begin : g_mcomb
         assign mul_lower = prod_now[7:0];
         assign mul_upper = prod_now[15:8];
      end else begin : g_mseq
         logic [15:0] dly [LAT];
         always @(posedge clk) begin
            dly[0] <= prod_now;
            for (int k = 1; k < LAT; k++) dly[k] <= dly[k-1];
         end
         assign mul_lower = dly[LAT-1][7:0];
         assign mul_upper = dly[LAT-1][15:8];
      end

      // Scoreboard: handshakes seen mid-cycle are the ones that happen at the next edge.
      always @(negedge clk) begin
         if (rst) begin
            sb.delete();
         end else begin
            if (rsp_valid && rsp_ready) begin
               if (sb.size() == 0) begin
                  checkOutput($sformatf("stale_rsp_lat%0d", LAT), 64'd1, 64'd0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  checkOutput($sformatf("rsp_data_lat%0d", LAT), 64'(rsp_data), 64'(e.data));
                  checkOutput($sformatf("rsp_tag_lat%0d", LAT), 64'(rsp_tag), 64'(e.tag));
               end
            end
            if (req_valid && req_ready) begin
               sb.push_back(refResult(req_a, req_b, req_unsign, req_high, req_tag));
               checkOutput($sformatf("outstanding_le4_lat%0d", LAT), 64'(sb.size() <= 4), 64'd1);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                                input logic u, input logic h, input logic [3:0] t);
      req_valid  = v;
      req_a      = a;
      req_b      = b;
      req_unsign = u;
      req_high   = h;
      req_tag    = t;
   endtask

   // Offer six back-to-back requests with no consumer; returns how many were taken.
   task automatic fillAndCount(output int acc);
      acc       = 0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 4'(acc));
         #1;
         if (g_dut[0].req_ready) acc++;
         tick();
      end
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0);
      #1;
   endtask

   initial begin : main
      int         acc;
      int         tags [$];
      int         nvalid;
      int         first;
      int         last;
      logic [7:0] dir_a   [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      logic       dir_u   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic       dir_h   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [7:0] dir_exp [4] = '{8'hFE, 8'h01, 8'hFF, 8'hFE};

      rst       = 1'b1;
      rsp_ready = 1'b1;
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0);
      repeat (3) begin
         tick();
         checkOutput("reset_req_ready", 64'(g_dut[0].req_ready), 64'd0);
         checkOutput("reset_rsp_valid", 64'(g_dut[0].rsp_valid), 64'd0);
      end
      rst = 1'b0;
      #1;
      checkOutput("post_reset_ready", 64'(g_dut[0].req_ready), 64'd1);

      applyStimulus(1'b0, 8'h5A, 8'h33, 1'b1, 1'b0, 4'h0);
      #1;
      checkOutput("mul_a_pass", 64'(g_dut[0].mul_a), 64'h5A);
      checkOutput("mul_b_pass", 64'(g_dut[0].mul_b), 64'h33);
      checkOutput("mul_unsign_pass", 64'(g_dut[0].mul_unsign), 64'd1);

      // Directed single operations with fixed latency checks on the LATENCY=1 build.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, dir_a[i], 8'h02, dir_u[i], dir_h[i], 4'd3);
         tick();
         applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0);
         #1;
         checkOutput("single_valid_c1", 64'(g_dut[0].rsp_valid), 64'd0);
         checkOutput("single_valid_c1_lat0", 64'(g_dut[1].rsp_valid), 64'd1);
         tick();
         checkOutput("single_valid_c2", 64'(g_dut[0].rsp_valid), 64'd1);
         checkOutput("single_data", 64'(g_dut[0].rsp_data), 64'(dir_exp[i]));
         checkOutput("single_tag", 64'(g_dut[0].rsp_tag), 64'd3);
         repeat (6) tick();
      end

      // Backpressure: only the four credits may be accepted, then drain in order.
      fillAndCount(acc);
      checkOutput("bp_accepted", 64'(acc), 64'd4);
      checkOutput("bp_ready_low", 64'(g_dut[0].req_ready), 64'd0);
      checkOutput("bp_ready_low_lat3", 64'(g_dut[2].req_ready), 64'd0);
      rsp_ready = 1'b1;
      tags.delete();
      for (int k = 0; k < 12; k++) begin
         if (g_dut[0].rsp_valid) tags.push_back(int'(g_dut[0].rsp_tag));
         tick();
      end
      checkOutput("bp_drain_count", 64'(tags.size()), 64'd4);
      for (int k = 0; k < tags.size() && k < 4; k++) checkOutput("bp_drain_tag", 64'(tags[k]), 64'(k));
      checkOutput("bp_ready_back", 64'(g_dut[0].req_ready), 64'd1);
      repeat (4) tick();

      // Streaming: sixteen back-to-back requests with an always-ready consumer.
      nvalid = 0;
      first  = -1;
      last   = -1;
      for (int it = 0; it < 24; it++) begin
         if (g_dut[0].rsp_valid) begin
            nvalid++;
            if (first < 0) first = it;
            last = it;
         end
         if (it < 16) begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 4'(it));
            #1;
            checkOutput("stream_ready", 64'(g_dut[0].req_ready), 64'd1);
         end else begin
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0);
         end
         tick();
      end
      checkOutput("stream_rsp_count", 64'(nvalid), 64'd16);
      checkOutput("stream_rsp_span", 64'(last - first), 64'd15);

      // Reset with results both buffered and still inside the multiplier.
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 4'(i));
         tick();
      end
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0);
      rst = 1'b1;
      #1;
      checkOutput("midrst_rsp_valid", 64'(g_dut[0].rsp_valid), 64'd0);
      checkOutput("midrst_req_ready", 64'(g_dut[0].req_ready), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("postrst_rsp_valid", 64'(g_dut[0].rsp_valid), 64'd0);
      checkOutput("postrst_req_ready", 64'(g_dut[0].req_ready), 64'd1);
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         checkOutput("postrst_no_stale", 64'(g_dut[0].rsp_valid | g_dut[2].rsp_valid), 64'd0);
         tick();
      end
      fillAndCount(acc);
      checkOutput("postrst_credits", 64'(acc), 64'd4);
      rsp_ready = 1'b1;
      repeat (10) tick();

      // Random traffic on all builds; the scoreboards check every response.
      for (int c = 0; c < 1500; c++) begin
         applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0);
      rsp_ready = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if (g_dut[0].sb.size() == 0 && g_dut[1].sb.size() == 0 && g_dut[2].sb.size() == 0) break;
         tick();
      end
      checkOutput("final_empty_lat1", 64'(g_dut[0].sb.size()), 64'd0);
      checkOutput("final_empty_lat0", 64'(g_dut[1].sb.size()), 64'd0);
      checkOutput("final_empty_lat3", 64'(g_dut[2].sb.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
